mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port main data memory between two requesters: the CPU datapath
//  (load/store stage) and the debug/loader port (memory inspection and program load).
//  Sits between both requesters and the main memory. Serialises accesses with a
//  request/grant/done handshake, drives the memory strobes for a fixed read latency,
//  and returns read data to the requester that was granted.
// PARAMETERS
//  ADDR_W   32  address width, both ports and memory side
//  DATA_W   32  data width
//  MEM_LAT  1   memory strobe/read latency in cycles; must be >=1, elaboration error if 0
// PORTS
//  clock        in   1       system clock; all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  cpu_req      in   1       CPU access request; held until cpu_gnt
//  cpu_we       in   1       1 = write, 0 = read (sampled with cpu_req)
//  cpu_addr     in   ADDR_W  CPU address
//  cpu_wdata    in   DATA_W  CPU write data
//  cpu_gnt      out  1       one-cycle pulse: CPU request accepted
//  cpu_done     out  1       one-cycle pulse: CPU access complete; cpu_rdata valid on reads
//  cpu_rdata    out  DATA_W  CPU read data
//  dbg_req / dbg_we / dbg_addr / dbg_wdata  in   same as cpu_*, debug port
//  dbg_gnt / dbg_done / dbg_rdata           out  same as cpu_*, debug port
//  mem_read     out  1       memory read strobe
//  mem_write    out  1       memory write strobe
//  mem_addr     out  ADDR_W  memory address
//  mem_wdata    out  DATA_W  memory write data
//  mem_rdata    in   DATA_W  memory read data, valid in last strobe cycle
// BEHAVIOUR
//  - Reset: state IDLE; all gnt/done/mem_read/mem_write = 0; mem_addr, mem_wdata,
//    cpu_rdata, dbg_rdata = 0; last_owner = DBG (CPU wins first contention); count = 0.
//  - FSM: IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: requests sampled only here. Any req -> pick owner, latch we/addr/wdata,
//    go BUSY, count = MEM_LAT-1. No req -> stay.
//  - BUSY: first BUSY cycle pulses owner's gnt. mem_read (read) or mem_write (write)
//    held high every BUSY cycle, mem_addr/mem_wdata = latched values.
//    count==0 -> capture mem_rdata into owner's rdata (reads only), go DONE, else count--.
//  - DONE: owner's done = 1 for exactly this cycle; strobes low; last_owner <= owner;
//    go IDLE.
//  - Timing: req first seen high in cycle t (IDLE) -> gnt at t+1, strobes t+1..t+MEM_LAT,
//    done at t+MEM_LAT+1. Min spacing between grants = MEM_LAT+2 cycles.
//  - Non-owner rdata and outputs unchanged during another port's access; rdata holds
//    until that port's next read completes.
//  - Requester deasserts req after gnt; a req still high in IDLE after done is a new access.
//  - Req dropped before gnt while arbiter busy: withdrawn, never granted.
//  - Write data/address changes after gnt: ignored (latched values used).
//  - Reset mid-access: next edge forces IDLE, strobes low, no gnt/done for the
//    abandoned access.
//  - Never both gnt or both done high; mem_read and mem_write never both high.
// CONFIGURATION
//  - MEM_ARB_RR_EN defined: round-robin. Both req in IDLE -> grant the port that is not
//    last_owner. Single req always granted.
//  - MEM_ARB_RR_EN undefined: fixed priority. CPU always wins contention; last_owner kept
//    but unused; debug can starve under continuous CPU traffic (documented, intended).
// TESTING
//  1. MEM_LAT=1, CPU read addr 0x10, mem_rdata=0xDEADBEEF -> cpu_gnt t+1, mem_read t+1,
//     cpu_done t+2, cpu_rdata=0xDEADBEEF.
//  2. Debug write addr 0x04 data 0x1234, then CPU read 0x04 (behavioural memory) ->
//     mem_write one cycle with addr 0x04, CPU reads 0x00001234.
//  3. MEM_ARB_RR_EN, both req held high for 4 accesses -> grant order CPU, DBG, CPU, DBG.
//  4. No MEM_ARB_RR_EN, same stimulus -> CPU, CPU, CPU, CPU; dbg_gnt never pulses.
//  5. MEM_LAT=3, CPU read -> mem_read high 3 cycles (t+1..t+3), cpu_done at t+4.
//  6. reset pulsed in second BUSY cycle (MEM_LAT=3) -> strobes 0 next cycle, no cpu_done,
//     following request served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and debug accesses onto one single-port memory.
// Define MEM_ARB_RR_EN for round-robin contention; otherwise the CPU always wins.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LAT < 1) begin : g_lat_chk
        $error("mem_port_arbiter: MEM_LAT must be >= 1");
    end

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              first_q, first_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              pick_dbg;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q;

    always_comb begin
        pick_dbg = 1'b0;
        if (cpu_req && dbg_req) begin
            pick_dbg = (last_owner_q == OWN_CPU);
        end else begin
            pick_dbg = dbg_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_owner_q <= OWN_DBG;
        end else if (state_q == ST_DONE) begin
            last_owner_q <= owner_q;
        end
    end
`else
    // CPU wins every contention; debug may starve under back-to-back CPU traffic.
    always_comb begin
        pick_dbg = dbg_req && !cpu_req;
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        count_d     = count_q;
        first_d     = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d = pick_dbg ? OWN_DBG : OWN_CPU;
                    we_d    = pick_dbg ? dbg_we : cpu_we;
                    addr_d  = pick_dbg ? dbg_addr : cpu_addr;
                    wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
                    count_d = CNT_W'(MEM_LAT - 1);
                    first_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (count_q == '0) begin
                    if (!we_q) begin
                        if (owner_q == OWN_DBG) begin
                            dbg_rdata_d = mem_rdata;
                        end else begin
                            cpu_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            count_q     <= '0;
            first_q     <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            count_q     <= count_d;
            first_q     <= first_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    logic busy;
    logic done;

    assign busy      = (state_q == ST_BUSY);
    assign done      = (state_q == ST_DONE);

    assign cpu_gnt   = busy && first_q && (owner_q == OWN_CPU);
    assign dbg_gnt   = busy && first_q && (owner_q == OWN_DBG);
    assign cpu_done  = done && (owner_q == OWN_CPU);
    assign dbg_done  = done && (owner_q == OWN_DBG);

    assign mem_read  = busy && !we_q;
    assign mem_write = busy && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed, table and random checks of mem_port_arbiter
// at read latencies 1 and 3; honours MEM_ARB_RR_EN for expected grant order.
module tb_mem_port_arbiter;

    localparam int LAT = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, reset3;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done;
    logic [31:0] cpu_rdata, dbg_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [16];

    logic        c3_req, c3_we, d3_req, d3_we;
    logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata;
    logic        c3_gnt, c3_done, d3_gnt, d3_done;
    logic [31:0] c3_rdata, d3_rdata;
    logic        m3_read, m3_write;
    logic [31:0] m3_addr, m3_wdata, m3_rdata;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_done(dbg_done),
        .dbg_rdata(dbg_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset(reset3),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr),
        .cpu_wdata(c3_wdata), .cpu_gnt(c3_gnt), .cpu_done(c3_done),
        .cpu_rdata(c3_rdata),
        .dbg_req(d3_req), .dbg_we(d3_we), .dbg_addr(d3_addr),
        .dbg_wdata(d3_wdata), .dbg_gnt(d3_gnt), .dbg_done(d3_done),
        .dbg_rdata(d3_rdata),
        .mem_read(m3_read), .mem_write(m3_write), .mem_addr(m3_addr),
        .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
    );

    // Behavioural memory: word per address nibble, preset on reset
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hDEADBEEF + 32'(i);
        end else if (mem_write) begin
            mem[mem_addr[3:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[3:0]];

    int checks = 0;
    int passes = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        creq;
        logic        dreq;
        logic        cwe;
        logic        dwe;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          own_rr;
        int          own_fp;
    } vec_t;
    vec_t vt[6];

    // Transaction-level reference model for the random phase
    int          e;
    bit          m_act;
    int          m_st;
    bit          m_own;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    bit          m_last;
    logic [31:0] mm [16];
    logic [31:0] x_crd, x_drd;
    logic        x_gnt, x_strobe, x_done;

    task automatic model_step();
        int d;
        if (!m_act || e >= m_st + LAT + 2) begin
            m_act = 1'b0;
            if (cpu_req || dbg_req) begin
                m_act = 1'b1;
                m_st  = e;
`ifdef MEM_ARB_RR_EN
                m_own = (cpu_req && dbg_req) ? !m_last : dbg_req;
`else
                m_own = !cpu_req;
`endif
                m_we    = m_own ? dbg_we : cpu_we;
                m_addr  = m_own ? dbg_addr : cpu_addr;
                m_wdata = m_own ? dbg_wdata : cpu_wdata;
                m_last  = m_own;
            end
        end
        d = e - m_st;
        x_gnt    = m_act && (d == 0);
        x_strobe = m_act && (d < LAT);
        x_done   = m_act && (d == LAT);
        if (x_done) begin
            if (m_we) mm[m_addr[3:0]] = m_wdata;
            else if (m_own) x_drd = mm[m_addr[3:0]];
            else x_crd = mm[m_addr[3:0]];
        end
    endtask

    task automatic drive_port(inout logic req, inout logic we,
                              inout logic [31:0] addr, inout logic [31:0] wd,
                              input logic gnt);
        if (req && gnt) begin
            req  = 1'b0;
            addr = $urandom;
            wd   = $urandom;
        end else if (req) begin
            if ($urandom_range(15) == 0) req = 1'b0;
        end else if ($urandom_range(3) == 0) begin
            req  = 1'b1;
            we   = 1'($urandom_range(1));
            addr = $urandom;
            wd   = $urandom;
        end
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    int ord[4];
    int n;
    int exp_own;
    bit seen;

    initial begin
        c3_req = 1'b0; c3_we = 1'b0; c3_addr = '0; c3_wdata = '0;
        d3_req = 1'b0; d3_we = 1'b0; d3_addr = '0; d3_wdata = '0;
        m3_rdata = '0;
        reset3 = 1'b1;
        do_reset();

        chk1("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk1("rst_cpu_done", cpu_done, 1'b0);
        chk1("rst_mem_read", mem_read, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk32("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk32("rst_dbg_rdata", dbg_rdata, 32'h0);

        // CPU read, latency 1
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        tick();
        chk1("t1_gnt", cpu_gnt, 1'b1);
        chk1("t1_read", mem_read, 1'b1);
        chk32("t1_addr", mem_addr, 32'h10);
        cpu_req = 1'b0;
        tick();
        chk1("t1_done", cpu_done, 1'b1);
        chk1("t1_read_off", mem_read, 1'b0);
        chk32("t1_rdata", cpu_rdata, 32'hDEADBEEF);
        tick();
        chk1("t1_done_off", cpu_done, 1'b0);

        // Debug write then CPU read-back
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h4; dbg_wdata = 32'h1234;
        tick();
        chk1("t2_dgnt", dbg_gnt, 1'b1);
        chk1("t2_write", mem_write, 1'b1);
        chk1("t2_nread", mem_read, 1'b0);
        chk32("t2_addr", mem_addr, 32'h4);
        chk32("t2_wdata", mem_wdata, 32'h1234);
        dbg_req = 1'b0; dbg_wdata = 32'hFFFF;
        tick();
        chk1("t2_ddone", dbg_done, 1'b1);
        chk1("t2_write_off", mem_write, 1'b0);
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h4;
        tick();
        chk1("t2_cgnt", cpu_gnt, 1'b1);
        cpu_req = 1'b0;
        tick();
        chk1("t2_cdone", cpu_done, 1'b1);
        chk32("t2_rdata", cpu_rdata, 32'h00001234);
        chk32("t2_dbg_hold", dbg_rdata, 32'h0);

        // Continuous contention: four grants
        do_reset();
        cpu_req = 1'b1; dbg_req = 1'b1;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            tick();
            if (cpu_gnt && n < 4) begin ord[n] = 1; n++; end
            if (dbg_gnt && n < 4) begin ord[n] = 2; n++; end
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        chk32("t3_ngrants", 32'(n), 32'd4);
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
            chk32("t3_rr_order", 32'(ord[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
`else
            chk32("t3_fp_order", 32'(ord[i]), 32'd1);
`endif
        end
        for (int i = 0; i < LAT + 2; i++) tick();

        // Arbitration table, run from a fresh reset (last owner = debug)
        vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1, 1};
        vt[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1, 32'h0, 2, 1};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h2, 32'hA5, 1, 1};
        vt[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3, 32'h5A, 2, 2};
        vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h6, 32'h77, 0, 0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h9, 32'h99, 1, 1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            exp_own = vt[i].own_rr;
`else
            exp_own = vt[i].own_fp;
`endif
            cpu_req = vt[i].creq; cpu_we = vt[i].cwe;
            cpu_addr = vt[i].addr; cpu_wdata = vt[i].wdata;
            dbg_req = vt[i].dreq; dbg_we = vt[i].dwe;
            dbg_addr = vt[i].addr ^ 32'h4; dbg_wdata = ~vt[i].wdata;
            tick();
            chk1("tbl_cgnt", cpu_gnt, exp_own == 1);
            chk1("tbl_dgnt", dbg_gnt, exp_own == 2);
            chk1("tbl_write", mem_write,
                 (exp_own == 1) ? vt[i].cwe : (exp_own == 2) ? vt[i].dwe : 1'b0);
            chk1("tbl_read", mem_read,
                 (exp_own == 1) ? !vt[i].cwe : (exp_own == 2) ? !vt[i].dwe : 1'b0);
            if (exp_own != 0)
                chk32("tbl_addr", mem_addr,
                      (exp_own == 1) ? vt[i].addr : vt[i].addr ^ 32'h4);
            cpu_req = 1'b0; dbg_req = 1'b0;
            tick();
            chk1("tbl_cdone", cpu_done, exp_own == 1);
            chk1("tbl_ddone", dbg_done, exp_own == 2);
            tick();
        end

        // Random traffic against the transaction model
        do_reset();
        for (int i = 0; i < 16; i++) mm[i] = 32'hDEADBEEF + 32'(i);
        m_act = 1'b0; m_st = -100; m_last = 1'b1;
        x_crd = '0; x_drd = '0; e = 0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            e++;
            model_step();
            chk1("rnd_cgnt", cpu_gnt, x_gnt && !m_own);
            chk1("rnd_dgnt", dbg_gnt, x_gnt && m_own);
            chk1("rnd_cdone", cpu_done, x_done && !m_own);
            chk1("rnd_ddone", dbg_done, x_done && m_own);
            chk1("rnd_read", mem_read, x_strobe && !m_we);
            chk1("rnd_write", mem_write, x_strobe && m_we);
            if (x_strobe) chk32("rnd_addr", mem_addr, m_addr);
            if (x_strobe && m_we) chk32("rnd_wdata", mem_wdata, m_wdata);
            chk32("rnd_crdata", cpu_rdata, x_crd);
            chk32("rnd_drdata", dbg_rdata, x_drd);
            drive_port(cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_gnt);
            drive_port(dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt);
        end
        idle_inputs();

        // Latency 3: strobe length and done timing
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        m3_rdata = 32'hCAFE0003;
        c3_req = 1'b1; c3_we = 1'b0; c3_addr = 32'h20;
        tick();
        chk1("l3_gnt", c3_gnt, 1'b1);
        chk1("l3_read1", m3_read, 1'b1);
        chk32("l3_addr", m3_addr, 32'h20);
        c3_req = 1'b0;
        tick();
        chk1("l3_read2", m3_read, 1'b1);
        chk1("l3_gnt_once", c3_gnt, 1'b0);
        chk1("l3_nodone2", c3_done, 1'b0);
        tick();
        chk1("l3_read3", m3_read, 1'b1);
        chk1("l3_nodone3", c3_done, 1'b0);
        tick();
        chk1("l3_read_off", m3_read, 1'b0);
        chk1("l3_done", c3_done, 1'b1);
        chk32("l3_rdata", c3_rdata, 32'hCAFE0003);
        tick();
        chk1("l3_done_off", c3_done, 1'b0);

        // Reset during the second BUSY cycle abandons the access
        m3_rdata = 32'h55AA55AA;
        c3_req = 1'b1; c3_addr = 32'h30;
        tick();
        chk1("rs_gnt", c3_gnt, 1'b1);
        c3_req = 1'b0;
        tick();
        chk1("rs_busy2", m3_read, 1'b1);
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        chk1("rs_read_off", m3_read, 1'b0);
        chk1("rs_write_off", m3_write, 1'b0);
        chk32("rs_rdata_clr", c3_rdata, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (c3_done || c3_gnt || m3_read) seen = 1'b1;
        end
        chk1("rs_no_done", seen, 1'b0);
        c3_req = 1'b1; c3_addr = 32'h34;
        tick();
        chk1("rs_regnt", c3_gnt, 1'b1);
        chk32("rs_readdr", m3_addr, 32'h34);
        c3_req = 1'b0;
        tick();
        tick();
        tick();
        chk1("rs_redone", c3_done, 1'b1);
        chk32("rs_rerdata", c3_rdata, 32'h55AA55AA);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
